// File: rtl/glb_block_arbiter_pkg.sv
// Shared types and constants for the GLB block arbiter.
// The header length field and the per-port block counter widths live here.
package glb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    PAYLOAD,
    DONE
  } state_t;

  localparam int LEN_WIDTH = 16;
  localparam int LEN_LSB   = 0;
  localparam int CNT_WIDTH = 4;

endpackage

// File: rtl/glb_skid_buffer.sv
// Two-entry registered valid/ready stage between the arbiter mux and the GLB port.
// Input ready depends only on fill level, so no combinational path runs from out_ready.
module glb_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [1:0]       fill_reg;
  logic [WIDTH-1:0] head_reg;
  logic [WIDTH-1:0] tail_reg;
  logic             push;
  logic             pop;

  assign in_ready  = (fill_reg != 2'd2);
  assign out_valid = (fill_reg != 2'd0);
  assign out_data  = head_reg;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_reg <= 2'd0;
      head_reg <= '0;
      tail_reg <= '0;
    end else if (flush) begin
      fill_reg <= 2'd0;
      head_reg <= '0;
      tail_reg <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (fill_reg == 2'd0) head_reg <= in_data;
          else                  tail_reg <= in_data;
          fill_reg <= fill_reg + 2'd1;
        end
        2'b01: begin
          head_reg <= tail_reg;
          fill_reg <= fill_reg - 2'd1;
        end
        2'b11: begin
          // Push while full is impossible, so only the one- and two-entry cases matter.
          if (fill_reg == 2'd1) begin
            head_reg <= in_data;
          end else begin
            head_reg <= tail_reg;
            tail_reg <= in_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/glb_block_arbiter.sv
// Round-robin arbiter that forwards whole length-prefixed blocks from NUM_PORTS
// streams onto one GLB write stream, raising done once every port has sent its quota.
module glb_block_arbiter
  import glb_arb_pkg::*;
#(
  parameter int NUM_PORTS       = 2,
  parameter int DATA_WIDTH      = 17,
  parameter int BLOCKS_PER_PORT = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 flush,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] in_data,
  input  logic [NUM_PORTS-1:0]                 in_valid,
  output logic [NUM_PORTS-1:0]                 in_ready,
  output logic [DATA_WIDTH-1:0]                out_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [$clog2(NUM_PORTS)-1:0]         out_port,
  output logic                                 out_last,
  output logic                                 block_done,
  output logic                                 done
);

  localparam int PW = $clog2(NUM_PORTS);
  localparam int SW = DATA_WIDTH + PW + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(BLOCKS_PER_PORT);

  state_t                             state_reg, state_next;
  logic [PW-1:0]                      grant_reg, rr_ptr_reg, pick;
  logic                               pick_valid;
  logic [LEN_WIDTH-1:0]               remaining_reg;
  logic [NUM_PORTS-1:0][CNT_WIDTH-1:0] count_reg;
  logic                               block_done_reg;
  logic [NUM_PORTS-1:0]               eligible, port_full;
  logic                               all_done, busy, skid_ready, sel_valid, xfer, last_word;
  logic [DATA_WIDTH-1:0]              sel_data;
  logic [LEN_WIDTH-1:0]               hdr_len;
  logic [SW-1:0]                      skid_out;
  int                                 idx;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      assign eligible[gi]  = in_valid[gi] && (count_reg[gi] < CNT_FULL);
      assign port_full[gi] = (count_reg[gi] == CNT_FULL);
      assign in_ready[gi]  = busy && skid_ready && (grant_reg == PW'(gi));
    end
  endgenerate

  assign all_done   = &port_full;
  assign busy       = (state_reg == HEADER) || (state_reg == PAYLOAD);
  assign sel_data   = in_data[grant_reg];
  assign sel_valid  = in_valid[grant_reg];
  assign hdr_len    = sel_data[LEN_LSB +: LEN_WIDTH];
  assign xfer       = busy && sel_valid && skid_ready;
  assign last_word  = (state_reg == HEADER) ? (hdr_len == '0) : (remaining_reg == LEN_WIDTH'(1));
  assign block_done = block_done_reg;
  assign done       = (state_reg == DONE);

  // Scan from farthest to nearest so the first eligible port at/after rr_ptr wins.
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    idx        = 0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_reg) + k;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (eligible[PW'(idx)]) begin
        pick       = PW'(idx);
        pick_valid = 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (all_done)        state_next = DONE;
        else if (pick_valid) state_next = HEADER;
      end
      HEADER:  if (xfer) state_next = last_word ? IDLE : PAYLOAD;
      PAYLOAD: if (xfer && last_word) state_next = IDLE;
      DONE:    state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      grant_reg      <= '0;
      rr_ptr_reg     <= '0;
      remaining_reg  <= '0;
      count_reg      <= '0;
      block_done_reg <= 1'b0;
    end else if (flush) begin
      state_reg      <= IDLE;
      grant_reg      <= '0;
      rr_ptr_reg     <= '0;
      remaining_reg  <= '0;
      count_reg      <= '0;
      block_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      block_done_reg <= xfer && last_word;
      if (state_reg == IDLE && pick_valid) grant_reg <= pick;
      if (xfer) remaining_reg <= (state_reg == HEADER) ? hdr_len : remaining_reg - LEN_WIDTH'(1);
      if (xfer && last_word) begin
        rr_ptr_reg <= (grant_reg == PW'(NUM_PORTS - 1)) ? '0 : grant_reg + PW'(1);
        if (count_reg[grant_reg] != CNT_FULL)
          count_reg[grant_reg] <= count_reg[grant_reg] + CNT_WIDTH'(1);
      end
    end
  end

  glb_skid_buffer #(
    .WIDTH(SW)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_data  ({last_word, grant_reg, sel_data}),
    .in_valid (busy && sel_valid),
    .in_ready (skid_ready),
    .out_data (skid_out),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  assign {out_last, out_port, out_data} = skid_out;

endmodule

// File: tb/tb_glb_block_arbiter.sv
// Bench for glb_block_arbiter: table rows, flush/reset sequences and random traffic,
// all checked against a block-level round-robin model of the expected output stream.
module tb_glb_block_arbiter;

  localparam int NP = 2;
  localparam int DW = 17;
  localparam int PW = $clog2(NP);

  typedef struct { logic [DW-1:0] data; bit first; } src_t;
  typedef struct { logic [DW-1:0] data; int port; bit last; } exp_t;
  typedef struct {
    bit bpp2; int len0a; int len1a; int len0b; int len1b;
    int rdy_pct; bit gaps; bit chk_bubble;
    int exp_words; int exp_blocks; bit exp_done;
  } vec_t;

  logic clk = 0, rst = 0, flush = 0, out_ready = 0, use2 = 0;
  logic [NP-1:0]         in_valid = '0;
  logic [NP-1:0][DW-1:0] in_data = '0;

  logic [NP-1:0] in_valid_a, in_valid_b, in_ready_a, in_ready_b, cur_in_ready;
  logic [DW-1:0] out_data_a, out_data_b, cur_out_data;
  logic [PW-1:0] out_port_a, out_port_b, cur_out_port;
  logic out_valid_a, out_valid_b, out_last_a, out_last_b, block_done_a, block_done_b, done_a, done_b;
  logic cur_out_valid, cur_out_last, cur_block_done, cur_done;

  assign in_valid_a     = use2 ? '0 : in_valid;
  assign in_valid_b     = use2 ? in_valid : '0;
  assign cur_in_ready   = use2 ? in_ready_b : in_ready_a;
  assign cur_out_data   = use2 ? out_data_b : out_data_a;
  assign cur_out_port   = use2 ? out_port_b : out_port_a;
  assign cur_out_valid  = use2 ? out_valid_b : out_valid_a;
  assign cur_out_last   = use2 ? out_last_b : out_last_a;
  assign cur_block_done = use2 ? block_done_b : block_done_a;
  assign cur_done       = use2 ? done_b : done_a;

  glb_block_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .BLOCKS_PER_PORT(1)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .in_data(in_data), .in_valid(in_valid_a),
    .in_ready(in_ready_a), .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_port(out_port_a), .out_last(out_last_a), .block_done(block_done_a), .done(done_a));

  glb_block_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .BLOCKS_PER_PORT(2)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .in_data(in_data), .in_valid(in_valid_b),
    .in_ready(in_ready_b), .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_port(out_port_b), .out_last(out_last_b), .block_done(block_done_b), .done(done_b));

  always #5 clk = ~clk;

  src_t src_q[NP][$];
  exp_t got_q[$];
  exp_t exp_q[$];
  logic [NP-1:0] in_fire = '0;
  bit   out_fire = 0;
  exp_t out_word;
  int cycle = 0, bd_cnt = 0, occ = 0, max_occ = 0, quiet = 0, ready_multi = 0;
  int hdr_cyc[NP], last_cyc[NP];
  int rdy_pct = 100;
  bit gaps = 0;
  int errors = 0, checks = 0;
  int exp_blocks = 0;
  bit exp_done = 0;

  // Retire last edge's handshakes, drive the next cycle, then sample handshakes.
  always @(negedge clk) begin
    cycle++;
    for (int p = 0; p < NP; p++) begin
      if (in_fire[p] && src_q[p].size() > 0) begin
        if (src_q[p][0].first) hdr_cyc[p] = cycle;
        last_cyc[p] = cycle;
        src_q[p].delete(0);
        occ++;
      end
    end
    if (out_fire) begin
      got_q.push_back(out_word);
      occ--;
    end
    if (occ > max_occ) max_occ = occ;
    if (cur_block_done) bd_cnt++;
    for (int p = 0; p < NP; p++) begin
      if (src_q[p].size() > 0 && !(gaps && !src_q[p][0].first && $urandom_range(0, 99) < 30)) begin
        in_valid[p] = 1'b1;
        in_data[p]  = src_q[p][0].data;
      end else begin
        in_valid[p] = 1'b0;
        in_data[p]  = '0;
      end
    end
    out_ready = ($urandom_range(0, 99) < rdy_pct);
    #1;
    in_fire  = in_valid & cur_in_ready;
    out_fire = cur_out_valid && out_ready;
    out_word = '{cur_out_data, int'(cur_out_port), cur_out_last};
    if ($countones(cur_in_ready) > 1) ready_multi++;
    if (in_fire == '0 && !cur_out_valid) quiet++;
    else quiet = 0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  function automatic logic [31:0] pack(input exp_t e);
    logic [1:0] pt;
    pt = e.port[1:0];
    return {12'd0, e.last, pt, e.data};
  endfunction

  task automatic clear_bench();
    for (int p = 0; p < NP; p++) begin
      src_q[p].delete();
      hdr_cyc[p]  = 0;
      last_cyc[p] = 0;
    end
    got_q.delete();
    in_fire = '0; out_fire = 0; in_valid = '0; in_data = '0;
    bd_cnt = 0; occ = 0; max_occ = 0; ready_multi = 0; quiet = 0;
  endtask

  task automatic do_reset(input bit sel);
    @(negedge clk);
    #3;
    rst  = 1'b1;
    use2 = sel;
    clear_bench();
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic add_block(input int p, input int len, input int tag);
    src_t s;
    s.data     = DW'(len);
    s.data[16] = 1'($urandom_range(0, 1));
    s.first    = 1'b1;
    src_q[p].push_back(s);
    for (int k = 0; k < len; k++) begin
      s.data  = DW'(32'h0000_000A + k + (p << 12) + (tag << 8));
      s.first = 1'b0;
      src_q[p].push_back(s);
    end
  endtask

  // Whole-block round robin over what each port has on offer.
  task automatic build_expect(input int bpp);
    src_t m[NP][$];
    int cnt[NP];
    int ptr, pk, n, q;
    for (int p = 0; p < NP; p++) begin
      m[p]   = src_q[p];
      cnt[p] = 0;
    end
    exp_q.delete();
    exp_blocks = 0;
    ptr = 0;
    while (1) begin
      pk = -1;
      for (int k = NP - 1; k >= 0; k--) begin
        q = (ptr + k) % NP;
        if (m[q].size() > 0 && cnt[q] < bpp) pk = q;
      end
      if (pk < 0) break;
      n = int'(m[pk][0].data[15:0]);
      exp_q.push_back('{m[pk][0].data, pk, n == 0});
      m[pk].delete(0);
      for (int j = 1; j <= n; j++) begin
        exp_q.push_back('{m[pk][0].data, pk, j == n});
        m[pk].delete(0);
      end
      cnt[pk]++;
      ptr = (pk + 1) % NP;
      exp_blocks++;
    end
    exp_done = 1'b1;
    for (int p = 0; p < NP; p++) if (cnt[p] != bpp) exp_done = 1'b0;
  endtask

  task automatic wait_quiet(input string name);
    int n;
    n = 0;
    quiet = 0;
    while (quiet < 16 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({name, " settle"}, 32'(n < 3000), 32'd1);
    #3;
  endtask

  task automatic compare_stream(input string name);
    chk({name, " words"}, got_q.size(), exp_q.size());
    for (int j = 0; j < got_q.size() && j < exp_q.size(); j++)
      chk($sformatf("%s word%0d", name, j), pack(got_q[j]), pack(exp_q[j]));
    chk({name, " block_done count"}, bd_cnt, exp_blocks);
    chk({name, " done"}, 32'(cur_done), 32'(exp_done));
    chk({name, " skid over 2"}, 32'(max_occ > 2), 32'd0);
    chk({name, " multiple in_ready"}, ready_multi, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    vec_t v;
    int n, sel, nb;
    string nm;

    //           bpp2 l0a l1a l0b l1b rdy gap bub words blks done
    vecs[0] = '{0,   3, -1, -1, -1, 100, 0, 0,  4, 1, 0};
    vecs[1] = '{0,   2,  1, -1, -1, 100, 0, 1,  5, 2, 1};
    vecs[2] = '{0,   8, -1, -1, -1,  50, 0, 0,  9, 1, 0};
    vecs[3] = '{0,  -1,  0, -1, -1, 100, 0, 0,  1, 1, 0};
    vecs[4] = '{1,   1,  1,  1,  1, 100, 0, 0,  8, 4, 1};
    vecs[5] = '{0,   2, -1,  1, -1, 100, 0, 0,  3, 1, 0};
    vecs[6] = '{0,   0,  0, -1, -1,  70, 0, 0,  2, 2, 1};
    vecs[7] = '{1,   3,  2,  0,  4,  60, 1, 0, 13, 4, 1};

    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("reset in_ready a", 32'(in_ready_a), 0);
    chk("reset out_valid a", 32'(out_valid_a), 0);
    chk("reset out_data a", 32'(out_data_a), 0);
    chk("reset out_port a", 32'(out_port_a), 0);
    chk("reset out_last a", 32'(out_last_a), 0);
    chk("reset block_done a", 32'(block_done_a), 0);
    chk("reset done a", 32'(done_a), 0);
    chk("reset in_ready b", 32'(in_ready_b), 0);
    chk("reset out_valid b", 32'(out_valid_b), 0);
    chk("reset done b", 32'(done_b), 0);

    for (int r = 0; r < 8; r++) begin
      v  = vecs[r];
      nm = $sformatf("row%0d", r);
      do_reset(v.bpp2);
      rdy_pct = v.rdy_pct;
      gaps    = v.gaps;
      if (v.len0a >= 0) add_block(0, v.len0a, 0);
      if (v.len0b >= 0) add_block(0, v.len0b, 1);
      if (v.len1a >= 0) add_block(1, v.len1a, 0);
      if (v.len1b >= 0) add_block(1, v.len1b, 1);
      build_expect(v.bpp2 ? 2 : 1);
      wait_quiet(nm);
      compare_stream(nm);
      chk({nm, " table words"}, got_q.size(), v.exp_words);
      chk({nm, " table blocks"}, bd_cnt, v.exp_blocks);
      chk({nm, " table done"}, 32'(cur_done), 32'(v.exp_done));
      if (v.chk_bubble) begin
        chk({nm, " idle gap"}, hdr_cyc[1] - last_cyc[0], 2);
        chk({nm, " block rate"}, last_cyc[0] - hdr_cyc[0], v.len0a);
      end
      $display("%s: words=%0d blocks=%0d done=%0d", nm, got_q.size(), bd_cnt, cur_done);
    end

    // Flush after header plus two payload words of a length-5 block.
    do_reset(0);
    rdy_pct = 100;
    gaps    = 0;
    add_block(0, 5, 0);
    n = 0;
    while (src_q[0].size() > 3 && n < 200) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("flush reach mid-block", 32'(n < 200), 32'd1);
    flush = 1'b1;
    @(negedge clk);
    #2;
    flush = 1'b0;
    chk("flush out_valid", 32'(cur_out_valid), 0);
    chk("flush block_done", 32'(cur_block_done), 0);
    chk("flush no block_done seen", bd_cnt, 0);
    chk("flush done", 32'(cur_done), 0);
    clear_bench();
    add_block(0, 1, 2);
    add_block(1, 1, 3);
    build_expect(1);
    wait_quiet("after flush");
    compare_stream("after flush");
    chk("after flush first port", (got_q.size() > 0) ? got_q[0].port : -1, 0);
    $display("flush: words=%0d blocks=%0d", got_q.size(), bd_cnt);

    // Asynchronous reset in the middle of a block.
    do_reset(1);
    rdy_pct = 100;
    add_block(0, 8, 0);
    n = 0;
    while (got_q.size() < 3 && n < 200) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("async reach mid-block", 32'(n < 200), 32'd1);
    chk("async out_valid before", 32'(cur_out_valid), 1);
    #1 rst = 1'b1;
    #1;
    chk("async in_ready", 32'(cur_in_ready), 0);
    chk("async out_valid", 32'(cur_out_valid), 0);
    chk("async out_data", 32'(cur_out_data), 0);
    chk("async out_port", 32'(cur_out_port), 0);
    chk("async out_last", 32'(cur_out_last), 0);
    chk("async block_done", 32'(cur_block_done), 0);
    chk("async done", 32'(cur_done), 0);
    $display("async reset: outputs sampled");

    for (int it = 0; it < 20; it++) begin
      sel = $urandom_range(0, 1);
      nm  = $sformatf("rand%0d", it);
      do_reset(sel[0]);
      rdy_pct = $urandom_range(30, 100);
      gaps    = 1'($urandom_range(0, 1));
      for (int p = 0; p < NP; p++) begin
        nb = $urandom_range(0, 3);
        for (int b = 0; b < nb; b++) add_block(p, $urandom_range(0, 6), b);
      end
      build_expect(sel ? 2 : 1);
      wait_quiet(nm);
      compare_stream(nm);
      $display("%s: bpp=%0d words=%0d blocks=%0d done=%0d", nm, sel + 1, got_q.size(), bd_cnt, cur_done);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/glb_block_arbiter.md
# glb_block_arbiter

Sequences and shares one GLB write stream between `NUM_PORTS` memory-core read-out streams. Every stream carries length-prefixed blocks: one header word whose low 16 bits give the payload length N, followed by N payload words. The arbiter grants whole blocks atomically in round-robin order and forwards them through a registered skid stage. It asserts `done` once every port has delivered `BLOCKS_PER_PORT` blocks. It sits between the memory-core output tiles and the GLB write port.

## Interface
- `NUM_PORTS`, default 2: number of requesting streams, at least 2.
- `DATA_WIDTH`, default 17: stream word width. Bits [15:0] of a header are the length; bit 16 is passed through untouched.
- `BLOCKS_PER_PORT`, default 1: blocks expected per port before `done`, in the range 1..15.
- `clk` input 1: clock.
- `rst` input 1: reset. Asynchronous and active-high.
- `flush` input 1: synchronous clear of all state.
- `in_data` input NUM_PORTS x DATA_WIDTH: per-port word.
- `in_valid` input NUM_PORTS: per-port valid.
- `in_ready` output NUM_PORTS: per-port ready.
- `out_data` output DATA_WIDTH: forwarded word.
- `out_valid` output 1: forwarded word valid.
- `out_ready` input 1: downstream ready.
- `out_port` output $clog2(NUM_PORTS): source port of `out_data`.
- `out_last` output 1: marks the final word of a block (the header itself when N=0).
- `block_done` output 1: one-cycle pulse when a block's last word is accepted from its input.
- `done` output 1: sticky flag; all ports have completed `BLOCKS_PER_PORT` blocks.

## Operation
- **Transfer rule.** A transfer on input i occurs when `in_valid[i]` and `in_ready[i]` are both high on a rising edge. The same rule applies to the output with `out_valid` and `out_ready`.
- **FSM states:** IDLE, HEADER, PAYLOAD, DONE.
- **IDLE**
  - Eligible ports are those with `in_valid` high and a block count below `BLOCKS_PER_PORT`.
  - The arbiter picks the first eligible port at or after `rr_ptr`, wrapping modulo `NUM_PORTS`.
  - It registers that port as `grant` and moves to HEADER.
  - With no eligible port, it stays in IDLE.
  - If every port's count equals `BLOCKS_PER_PORT`, it moves to DONE.
- **HEADER**
  - `in_ready[grant]` equals the skid stage's input ready. All other `in_ready` bits are 0.
  - On a transfer, it loads `remaining = in_data[15:0]` and forwards the header word.
  - If N=0, the block completes and the FSM returns to IDLE. Otherwise it moves to PAYLOAD.
- **PAYLOAD**
  - Same ready rule as HEADER.
  - Each transfer forwards the word and decrements `remaining`.
  - The transfer that takes `remaining` from 1 to 0 completes the block and returns the FSM to IDLE.
- **Block completion**
  - `block_done` pulses for one cycle.
  - `count[grant]` increments, saturating at `BLOCKS_PER_PORT`.
  - `rr_ptr` becomes (grant+1) mod `NUM_PORTS`.
  - The completing word enters the skid stage with `out_last` set.
- **DONE**
  - `done` is 1 and all `in_ready` bits are 0.
  - The FSM leaves DONE only on `flush` or `rst`.
  - Words still in the skid stage continue to drain.
- **Flush** (takes priority over every other event in the same cycle)
  - Returns the FSM to IDLE.
  - Clears `grant`, `rr_ptr`, `remaining`, all counts and `done`.
  - Empties the skid stage.
  - Any partial block is discarded. No `block_done` is produced for it.
- **Width rules**
  - `remaining` is 16 bits.
  - Each per-port count is 4 bits.
  - N=65535 is legal. No length clamping is performed.

## Timing
- **Reset values:** `in_ready`=0, `out_valid`=0, `out_data`=0, `out_port`=0, `out_last`=0, `block_done`=0, `done`=0, FSM in IDLE, `rr_ptr`=0.
- **Latency:** an input transfer at edge k makes `out_valid` high after edge k (it is registered). `out_data` and `out_ready` have no combinational path to the inputs.
- **Throughput:** one word per cycle within a block. Arbitration in IDLE costs exactly one bubble cycle between blocks.
- **Ready path:** `in_ready` is registered-state-derived (FSM, `grant`, skid-stage occupancy). It never depends combinationally on `in_valid` or `out_ready`.
- **Backpressure:** with `out_ready` held low, the skid stage accepts at most 2 words, after which `in_ready[grant]` drops the following cycle.
- **Granted port drops valid mid-block:** the grant is held and no other port is served until that block completes.
- **Simultaneous valid in IDLE:** only the round-robin winner is granted. The losing ports see `in_ready` low.
- **Mid-operation assertion:** `rst` mid-operation returns all outputs to reset values asynchronously.

## Structure
- **Package `glb_arb_pkg`:**
  - state enum (IDLE, HEADER, PAYLOAD, DONE);
  - `LEN_WIDTH`=16 and `LEN_LSB`=0 constants for the header field;
  - count-width constant.
- **Sub-module `glb_skid_buffer`:**
  - 2-entry registered valid/ready stage;
  - carries `{out_last, out_port, data}`;
  - `rst`/`flush` clear it.
- **Top:** FSM, round-robin pointer, per-port counters and the input mux.

## Test plan
1. **Single block:** port0 sends header 3 then 0xA,0xB,0xC with `out_ready`=1 → output header 3, A, B, C on `out_port` 0, `out_last` on C, one `block_done`, `done`=1 with port1 ignored only if `BLOCKS_PER_PORT` is satisfied for all ports (otherwise `done` stays 0).
2. **Contention:** both ports valid at once, after reset, with blocks of lengths 2 and 1 → port0's block is output entirely first, then port1's, with one idle cycle between. `done`=1 after port1's last word is accepted.
3. **Backpressure:** `out_ready` random at 50% while port0 sends header 8 plus 8 words → all 9 words arrive in order with none duplicated or lost, and at most 2 words are accepted while `out_ready` is low.
4. **Zero length:** port1 sends header 0 → a single output word 0 with `out_last`=1 and `block_done` pulsed. The FSM is back in IDLE on the next cycle.
5. **Flush mid-block:** port0 sends header 5 plus 2 words, then `flush` pulses → `out_valid`=0 on the next cycle and no `block_done`. A fresh header-1 block afterwards completes normally from `rr_ptr`=0.
6. **`BLOCKS_PER_PORT`=2 and async reset:** each port sends two blocks of length 1 → the grant order is 0,1,0,1 and `done` rises after the fourth `block_done`. Asserting `rst` mid-block zeroes all outputs immediately.
